// File: rtl/sample_buffer_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_slave_if
// Description : Avalon-MM bus bundle between the FIR accelerator's master and
//               the sample buffer responder.
//               master modport : drives address/read/write/writedata/byteenable
//               slave  modport : drives readdata/waitrequest
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_buffer_slave_if;
  logic [9:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/sample_buffer_slave.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_slave
// Description : Avalon-MM responder holding the FIR accelerator's input and
//               output sample blocks. Fills the input half from a stream sink,
//               raises coe_start_export, serves the master, then drains the
//               output half on a stream source once the master finishes.
// Ports       : clk, reset_n (async, active-low)
//               bus      - Avalon-MM slave (address/read/write/writedata/
//                          byteenable/readdata/waitrequest)
//               snk_*    - input sample stream (valid/ready/data)
//               src_*    - output sample stream (valid/ready/data)
//               coe_*    - start (out), finish (in, level), err (out, sticky)
// Options     : SAMPLE_BUFFER_BYTEENABLE_EN - when defined, Avalon writes
//               honour avs_byteenable; otherwise full words are written.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_buffer_slave #(
  parameter int SIZE         = 128,
  parameter int OFFSET_SAIDA = 512,
  parameter int WAIT_STATES  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sample_buffer_slave_if.slave bus,
  input  logic                 snk_valid,
  input  logic [31:0]          snk_data,
  output logic                 snk_ready,
  output logic                 src_valid,
  output logic [31:0]          src_data,
  input  logic                 src_ready,
  output logic                 coe_start_export,
  input  logic                 coe_finish_export,
  output logic                 coe_err_export
);

  localparam int DEPTH  = 2 * SIZE;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(SIZE + 1);
  // One spare bit so the counter can saturate above SIZE without wrapping back.
  localparam int OCNT_W = $clog2(SIZE + 1) + 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [3:0]        cnt;
  logic [PTR_W-1:0]  in_ptr;
  logic [PTR_W-1:0]  drain_ptr;
  logic [OCNT_W-1:0] out_cnt;
  logic              err;

  logic              req;
  logic              wait_req;
  logic              wr_done;
  logic              out_half;
  logic [31:0]       addr_mod;
  logic [31:0]       word_idx;
  logic              in_range;
  logic [MEM_AW-1:0] mem_addr;
  logic              av_we;
  logic              snk_fire;
  logic              drain_load;
  logic              drain_done;

  // --------------------------------------------------------------------------
  // Address decode: lower half below OFFSET_SAIDA, upper half above it; the
  // word index is taken modulo the region size so aliases land in range checks.
  // --------------------------------------------------------------------------
  assign out_half = ({22'd0, bus.avs_address} >= 32'(OFFSET_SAIDA));
  assign addr_mod = {22'd0, bus.avs_address} & 32'(OFFSET_SAIDA - 1);
  assign word_idx = addr_mod >> 2;
  assign in_range = (word_idx < 32'(SIZE));
  assign mem_addr = MEM_AW'(out_half ? (32'(SIZE) + word_idx) : word_idx);

  // --------------------------------------------------------------------------
  // Avalon handshake: a request stalls until cnt reaches WAIT_STATES.
  // --------------------------------------------------------------------------
  assign req                 = bus.avs_read | bus.avs_write;
  assign wait_req            = req & (cnt != 4'(WAIT_STATES));
  assign bus.avs_waitrequest = wait_req;
  assign wr_done             = bus.avs_write & ~wait_req;
  assign av_we               = wr_done & in_range;
  assign snk_fire            = snk_valid & snk_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (!req || !wait_req) begin
      // Idle, withdrawn request, or completion cycle all restart the count.
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Sample storage: one write port shared by Avalon and the sink. The sink is
  // held off (snk_ready low) whenever an Avalon write completes, so the two
  // never need the port in the same cycle.
  // --------------------------------------------------------------------------
`ifdef SAMPLE_BUFFER_BYTEENABLE_EN
  always_ff @(posedge clk) begin
    if (av_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.avs_byteenable[b]) begin
          mem[mem_addr][8*b +: 8] <= bus.avs_writedata[8*b +: 8];
        end
      end
    end else if (snk_fire) begin
      mem[MEM_AW'(in_ptr)] <= snk_data;
    end
  end
`else
  logic unused_byteenable;
  assign unused_byteenable = ^bus.avs_byteenable;

  always_ff @(posedge clk) begin
    if (av_we) begin
      mem[mem_addr] <= bus.avs_writedata;
    end else if (snk_fire) begin
      mem[MEM_AW'(in_ptr)] <= snk_data;
    end
  end
`endif

  // Read data follows the address every cycle, so it is ready by the
  // completion cycle of any stalled read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.avs_readdata <= 32'd0;
    end else begin
      bus.avs_readdata <= in_range ? mem[mem_addr] : 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    snk_ready        = 1'b0;
    coe_start_export = 1'b0;
    drain_load       = 1'b0;
    drain_done       = 1'b0;
    unique case (state)
      S_FILL: begin
        snk_ready = (in_ptr != PTR_W'(SIZE)) & ~wr_done;
        if (snk_valid && !wr_done && (in_ptr == PTR_W'(SIZE - 1))) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        coe_start_export = 1'b1;
        if (coe_finish_export) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Fetch the next word whenever the output register is empty or is
        // being emptied this cycle.
        drain_load = (drain_ptr != PTR_W'(SIZE)) & (~src_valid | src_ready);
        drain_done = src_valid & src_ready & (drain_ptr == PTR_W'(SIZE));
        if (drain_done) begin
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, counters, error flag and the source output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ptr    <= '0;
      drain_ptr <= '0;
      out_cnt   <= '0;
      err       <= 1'b0;
      src_valid <= 1'b0;
      src_data  <= 32'd0;
    end else begin
      if (snk_fire) begin
        in_ptr <= in_ptr + PTR_W'(1);
      end

      if (av_we && out_half && (out_cnt != '1)) begin
        out_cnt <= out_cnt + OCNT_W'(1);
      end

      if ((state == S_RUN) && coe_finish_export) begin
        err       <= err | (out_cnt != OCNT_W'(SIZE));
        drain_ptr <= '0;
      end

      if (drain_load) begin
        src_data  <= mem[MEM_AW'(SIZE) + MEM_AW'(drain_ptr)];
        src_valid <= 1'b1;
        drain_ptr <= drain_ptr + PTR_W'(1);
      end else if (src_ready) begin
        src_valid <= 1'b0;
      end

      if (drain_done) begin
        in_ptr  <= '0;
        out_cnt <= '0;
      end
    end
  end

  assign coe_err_export = err;

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_buffer_slave
// Description : Self-checking bench for sample_buffer_slave. Random sample
//               data, gaps, write orders and stream stalls are checked against
//               a behavioural model of the two sample regions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_buffer_slave;

  localparam int SIZE         = 32;
  localparam int OFFSET_SAIDA = 512;
  localparam int WAIT_STATES  = 1;
`ifdef SAMPLE_BUFFER_BYTEENABLE_EN
  localparam logic [31:0] BE_EXP = 32'h1122CCDD;
`else
  localparam logic [31:0] BE_EXP = 32'hAABBCCDD;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        snk_valid = 1'b0;
  logic [31:0] snk_data = 32'd0;
  logic        snk_ready;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready = 1'b0;
  logic        coe_start_export;
  logic        coe_finish_export = 1'b0;
  logic        coe_err_export;

  always #5 clk = ~clk;

  sample_buffer_slave_if bus ();

  sample_buffer_slave #(
    .SIZE(SIZE), .OFFSET_SAIDA(OFFSET_SAIDA), .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .coe_start_export(coe_start_export), .coe_finish_export(coe_finish_export),
    .coe_err_export(coe_err_export)
  );

  // Behavioural model: contents of both regions plus the bookkeeping counts.
  logic [31:0] in_m  [SIZE];
  logic [31:0] out_m [SIZE];
  int          out_cnt_m = 0;
  int          in_ptr_m  = 0;
  bit          err_m     = 1'b0;
  int          tests     = 0;
  int          fails     = 0;
  int          perm [SIZE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = d;
`ifdef SAMPLE_BUFFER_BYTEENABLE_EN
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
`else
    if (be == 4'hx) r = old;
`endif
    return r;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    idx = (a % OFFSET_SAIDA) / 4;
    if (idx < SIZE) begin
      if (a >= OFFSET_SAIDA) begin
        out_m[idx] = merge(out_m[idx], d, be);
        out_cnt_m++;
      end else begin
        in_m[idx] = merge(in_m[idx], d, be);
      end
    end
  endtask

  // One Avalon transfer; the stall length is checked on every transfer.
  task automatic av_xfer(input bit wr, input int a, input logic [31:0] d, input logic [3:0] be,
                         input bit chk_rd, input logic [31:0] exp_rd, input string tag);
    int n;
    n = 0;
    bus.avs_address    = 10'(a);
    bus.avs_writedata  = d;
    bus.avs_byteenable = be;
    bus.avs_write      = wr;
    bus.avs_read       = !wr;
    #1;
    while (bus.avs_waitrequest === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(n), 32'(WAIT_STATES));
    if (!wr && chk_rd) check(tag, bus.avs_readdata, exp_rd);
    tick();
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    if (wr) model_write(a, d, be);
  endtask

  task automatic snk_send(input logic [31:0] d);
    int n;
    n = 0;
    snk_valid = 1'b1;
    snk_data  = d;
    #1;
    while (snk_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("snk_timeout", 32'(n), 32'd0);
    tick();
    snk_valid = 1'b0;
    in_m[in_ptr_m] = d;
    in_ptr_m++;
  endtask

  // Sample offered exactly in the completion cycle of an out-of-range write.
  task automatic collide_send(input logic [31:0] d);
    bus.avs_address   = 10'(OFFSET_SAIDA + 4 * SIZE);
    bus.avs_writedata = $urandom();
    bus.avs_byteenable = 4'hF;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b0;
    repeat (WAIT_STATES) tick();
    snk_valid = 1'b1;
    snk_data  = d;
    #1;
    check("collide_wait", 32'(bus.avs_waitrequest), 32'd0);
    check("collide_rdy_low", 32'(snk_ready), 32'd0);
    tick();
    bus.avs_write = 1'b0;
    #1;
    check("collide_rdy_back", 32'(snk_ready), 32'd1);
    tick();
    snk_valid = 1'b0;
    in_m[in_ptr_m] = d;
    in_ptr_m++;
  endtask

  task automatic fill_block();
    for (int i = 0; i < SIZE; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == SIZE - 1) check("start_before_full", 32'(coe_start_export), 32'd0);
      if (i == SIZE / 2) collide_send($urandom());
      else               snk_send($urandom());
    end
    check("full_rdy_low", 32'(snk_ready), 32'd0);
    check("start_high", 32'(coe_start_export), 32'd1);
  endtask

  // Master activity in RUN: input reads, nwr shuffled output writes, OOR access.
  task automatic run_block(input int nwr);
    int j, t;
    for (int i = 0; i < 4; i++) begin
      j = $urandom_range(0, SIZE - 1);
      av_xfer(1'b0, 4 * j, 32'd0, 4'h0, 1'b1, in_m[j], "rd_in");
    end
    av_xfer(1'b0, 16, 32'd0, 4'h0, 1'b1, in_m[4], "rd_0x010");
    for (int i = 0; i < SIZE; i++) perm[i] = i;
    for (int i = SIZE - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < nwr; i++) begin
      av_xfer(1'b1, OFFSET_SAIDA + 4 * perm[i], $urandom(), 4'hF, 1'b0, 32'd0, "wr_out");
    end
    j = $urandom_range(SIZE, (1024 - OFFSET_SAIDA) / 4 - 1);
    av_xfer(1'b1, OFFSET_SAIDA + 4 * j, $urandom(), 4'hF, 1'b0, 32'd0, "wr_oor");
    av_xfer(1'b0, OFFSET_SAIDA + 4 * j, 32'd0, 4'h0, 1'b1, 32'd0, "rd_oor");
    av_xfer(1'b0, OFFSET_SAIDA + 4 * perm[0], 32'd0, 4'h0, 1'b1, out_m[perm[0]], "rd_out");
    check("start_in_run", 32'(coe_start_export), 32'd1);
  endtask

  task automatic finish_pulse();
    coe_finish_export = 1'b1;
    tick();
    coe_finish_export = 1'b0;
    err_m = err_m | (out_cnt_m != SIZE);
    check("start_fall", 32'(coe_start_export), 32'd0);
    check("src_valid_entry", 32'(src_valid), 32'd0);
    check("err_after_run", 32'(coe_err_export), 32'(err_m));
    tick();
    check("src_valid_first", 32'(src_valid), 32'd1);
  endtask

  task automatic drain_block(input bit rand_ready);
    int k, n;
    k = 0;
    n = 0;
    while (k < SIZE && n < 20 * SIZE) begin
      src_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (src_valid) begin
        check("drain_data", src_data, out_m[k]);
        if (src_ready) k++;
      end
      tick();
      n++;
    end
    src_ready = 1'b0;
    if (k < SIZE) check("drain_timeout", 32'(k), 32'(SIZE));
    if (!rand_ready) check("drain_rate", 32'(n), 32'(SIZE));
    check("back_fill_rdy", 32'(snk_ready), 32'd1);
    check("back_fill_valid", 32'(src_valid), 32'd0);
    check("err_after_drain", 32'(coe_err_export), 32'(err_m));
    out_cnt_m = 0;
    in_ptr_m  = 0;
  endtask

  initial begin
    bus.avs_address    = 10'd0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_writedata  = 32'd0;
    bus.avs_byteenable = 4'h0;
    repeat (3) tick();
    check("rst_readdata", bus.avs_readdata, 32'd0);
    check("rst_src_data", src_data, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_wait", 32'(bus.avs_waitrequest), 32'd0);
    check("rst_snk_ready", 32'(snk_ready), 32'd1);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_start", 32'(coe_start_export), 32'd0);
    check("rst_err", 32'(coe_err_export), 32'd0);

    // Byte-lane write to input word 0x44.
    av_xfer(1'b1, 32'h44, 32'h11223344, 4'hF, 1'b0, 32'd0, "be_init");
    av_xfer(1'b1, 32'h44, 32'hAABBCCDD, 4'h3, 1'b0, 32'd0, "be_wr");
    av_xfer(1'b0, 32'h44, 32'd0, 4'h0, 1'b1, BE_EXP, "be_rd");
    av_xfer(1'b0, 4 * SIZE, 32'd0, 4'h0, 1'b1, 32'd0, "rd_in_oor");

    // finish is ignored while filling.
    coe_finish_export = 1'b1;
    tick();
    coe_finish_export = 1'b0;
    check("finish_ign_rdy", 32'(snk_ready), 32'd1);
    check("finish_ign_valid", 32'(src_valid), 32'd0);

    // Block 1: complete output block, random stream stalls.
    fill_block();
    run_block(SIZE);
    finish_pulse();
    drain_block(1'b1);

    // Block 2: one output write short -> sticky error; full-rate drain.
    fill_block();
    run_block(SIZE - 1);
    finish_pulse();
    drain_block(1'b0);

    // Block 3: complete block, error stays set; reset in the middle of drain.
    fill_block();
    run_block(SIZE);
    finish_pulse();
    src_ready = 1'b1;
    repeat (3) tick();
    src_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(src_valid), 32'd0);
    check("mid_rst_err", 32'(coe_err_export), 32'd0);
    check("mid_rst_snk_rdy", 32'(snk_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    err_m = 1'b0;
    tick();
    av_xfer(1'b0, OFFSET_SAIDA + 4 * perm[1], 32'd0, 4'h0, 1'b1, out_m[perm[1]], "retain_out");
    av_xfer(1'b0, 8, 32'd0, 4'h0, 1'b1, in_m[2], "retain_in");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
